// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: PC-1 on load, per-round C/D rotation,
// PC-2 presented combinationally from the C/D registers.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        advance,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        valid,
  output logic        last
);

  // Tables hold FIPS 46-3 bit numbers (1 = MSB of the source vector).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_round;
  logic        r_mode;   // 1 = decrypt order (K16 first)
  logic        r_valid;

  logic [55:0] w_pc1;
  logic [55:0] w_cd;
  logic [47:0] w_subkey;
  logic [4:0]  w_keynum;
  logic        w_shift_one;
  logic [27:0] w_c_next;
  logic [27:0] w_d_next;

  function automatic logic [27:0] rot(input logic [27:0] x, input logic right,
                                      input logic one);
    logic [27:0] y;
    if (right) y = one ? {x[0], x[27:1]}   : {x[1:0], x[27:2]};
    else       y = one ? {x[26:0], x[27]}  : {x[25:0], x[27:26]};
    return y;
  endfunction

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign w_pc1[55-i] = key[64-PC1[i]];
  end

  assign w_cd = {r_c, r_d};
  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign w_subkey[47-j] = w_cd[56-PC2[j]];
  end

  // Encrypt rotates toward the next key number; decrypt undoes the current one.
  assign w_keynum    = r_mode ? (5'd16 - {1'b0, r_round}) : ({1'b0, r_round} + 5'd2);
  assign w_shift_one = (w_keynum == 5'd1) || (w_keynum == 5'd2) ||
                       (w_keynum == 5'd9) || (w_keynum == 5'd16);
  assign w_c_next    = rot(r_c, r_mode, w_shift_one);
  assign w_d_next    = rot(r_d, r_mode, w_shift_one);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_mode  <= 1'b0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_mode  <= decrypt;
      r_valid <= 1'b1;
      r_round <= '0;
      if (decrypt) begin
        r_c <= w_pc1[55:28];
        r_d <= w_pc1[27:0];
      end else begin
        r_c <= rot(w_pc1[55:28], 1'b0, 1'b1);
        r_d <= rot(w_pc1[27:0], 1'b0, 1'b1);
      end
    end else if (advance && r_valid) begin
      if (r_round == 4'd15) begin
        r_valid <= 1'b0;
        r_round <= '0;
      end else begin
        r_round <= r_round + 4'd1;
        r_c     <= w_c_next;
        r_d     <= w_d_next;
      end
    end
  end

  assign subkey = w_subkey;
  assign round  = r_round;
  assign valid  = r_valid;
  assign last   = r_valid && (r_round == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known FIPS vectors plus a reference model that
// builds all 16 subkeys from cumulative shift totals.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        advance = 1'b0;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        valid;
  logic        last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs [16];
  logic [47:0] obs_enc [16];
  logic [47:0] obs_par [16];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123456789BBCDEF0;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .key     (key),
    .decrypt (decrypt),
    .advance (advance),
    .subkey  (subkey),
    .round   (round),
    .valid   (valid),
    .last    (last)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    advance = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Reference model: Kn = PC-2(rotl(C0, T_n) || rotl(D0, T_n)), T_n = sum of shifts 1..n.
  task automatic model_keys(input logic [63:0] k, input logic dec);
    logic [27:0] c0, d0, cn, dn;
    logic [55:0] cd;
    logic [47:0] kn;
    logic [47:0] ks [16];
    int total;
    for (int i = 0; i < 28; i++) begin
      c0[27-i] = k[64-M_PC1[i]];
      d0[27-i] = k[64-M_PC1[i+28]];
    end
    total = 0;
    for (int n = 0; n < 16; n++) begin
      total = total + M_SHIFTS[n];
      cn = (c0 << total) | (c0 >> (28 - total));
      dn = (d0 << total) | (d0 >> (28 - total));
      cd = {cn, dn};
      for (int j = 0; j < 48; j++) kn[47-j] = cd[56-M_PC2[j]];
      ks[n] = kn;
    end
    exp_q.delete();
    for (int n = 0; n < 16; n++) exp_q.push_back(dec ? ks[15-n] : ks[n]);
  endtask

  task automatic pulse_load(input logic [63:0] k, input logic dec);
    load = 1'b1;
    key = k;
    decrypt = dec;
    step();
    load = 1'b0;
    key = {$urandom, $urandom};
    decrypt = 1'($urandom_range(0, 1));
  endtask

  // Full schedule with model scoreboard; observed subkeys kept in obs[].
  task automatic run_full(input logic [63:0] k, input logic dec, input bit gaps);
    logic [47:0] exp;
    model_keys(k, dec);
    advance = 1'b0;
    pulse_load(k, dec);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int idle = $urandom_range(0, 2);
        for (int g = 0; g < idle; g++) begin
          advance = 1'b0;
          step();
        end
      end
      exp = exp_q.pop_front();
      obs[i] = subkey;
      n_tests++;
      if (subkey !== exp || round !== 4'(i) || valid !== 1'b1 || last !== (i == 15)) begin
        n_fail++;
        $display("FAIL sched key=%h dec=%0b i=%0d: subkey=%h round=%0d valid=%b last=%b, want %h %0d 1 %b",
                 k, dec, i, subkey, round, valid, last, exp, i, (i == 15));
      end
      advance = 1'b1;
      step();
      advance = 1'b0;
    end
    n_tests++;
    if (valid !== 1'b0 || round !== 4'd0 || last !== 1'b0) begin
      n_fail++;
      $display("FAIL sched_end key=%h: valid=%b round=%0d last=%b, want 0 0 0", k, valid, round, last);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (valid !== 1'b0 || round !== 4'd0 || subkey !== 48'h0 || last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: valid=%b round=%0d subkey=%h last=%b, want 0 0 0 0", valid, round, subkey, last);
    end
    pulse_load(KEY_A, 1'b0);
    advance = 1'b1;
    repeat (7) step();
    advance = 1'b0;
    n_tests++;
    if (round !== 4'd7 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: round=%0d valid=%b, want 7 1", round, valid);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (valid !== 1'b0 || round !== 4'd0 || subkey !== 48'h0 || last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b round=%0d subkey=%h last=%b, want 0 0 0 0", valid, round, subkey, last);
    end
    step();
    rst = 1'b0;
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (valid !== 1'b0 || round !== 4'd0 || subkey !== 48'h0) begin
        n_fail++;
        $display("FAIL reset_adv: valid=%b round=%0d subkey=%h, want 0 0 0", valid, round, subkey);
      end
    end
    advance = 1'b0;
  endtask

  task automatic test_encrypt();
    run_full(KEY_A, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) obs_enc[i] = obs[i];
    n_tests++;
    if (obs[0] !== 48'h1B02EFFC7072 || obs[1] !== 48'h79AED9DBC9E5 || obs[15] !== 48'hCB3D8B0E17F5) begin
      n_fail++;
      $display("FAIL enc_vectors: K1=%h K2=%h K16=%h, want 1b02effc7072 79aed9dbc9e5 cb3d8b0e17f5",
               obs[0], obs[1], obs[15]);
    end
  endtask

  task automatic test_decrypt();
    run_full(KEY_A, 1'b1, 1'b0);
    n_tests++;
    if (obs[0] !== 48'hCB3D8B0E17F5 || obs[15] !== 48'h1B02EFFC7072) begin
      n_fail++;
      $display("FAIL dec_vectors: first=%h last=%h, want cb3d8b0e17f5 1b02effc7072", obs[0], obs[15]);
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (obs[i] !== obs_enc[15-i]) begin
        n_fail++;
        $display("FAIL dec_reverse i=%0d: dec=%h enc=%h", i, obs[i], obs_enc[15-i]);
      end
    end
  endtask

  task automatic test_parity();
    run_full(KEY_P, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) obs_par[i] = obs[i];
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (obs_par[i] !== obs_enc[i]) begin
        n_fail++;
        $display("FAIL parity i=%0d: got %h want %h", i, obs_par[i], obs_enc[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [47:0] exp;
    pulse_load(KEY_A, 1'b0);
    advance = 1'b1;
    repeat (9) step();
    model_keys(KEY_B, 1'b0);
    exp = exp_q.pop_front();
    load = 1'b1;
    key = KEY_B;
    decrypt = 1'b0;
    step();
    load = 1'b0;
    advance = 1'b0;
    n_tests++;
    if (round !== 4'd0 || subkey !== exp || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL priority: round=%0d subkey=%h valid=%b, want 0 %h 1", round, subkey, valid, exp);
    end
    advance = 1'b1;
    step();
    advance = 1'b0;
    exp = exp_q.pop_front();
    n_tests++;
    if (round !== 4'd1 || subkey !== exp) begin
      n_fail++;
      $display("FAIL priority_next: round=%0d subkey=%h, want 1 %h", round, subkey, exp);
    end
  endtask

  task automatic test_idle_advance();
    logic [47:0] held;
    logic [47:0] exp;
    run_full(KEY_B, 1'b1, 1'b0);
    held = obs[15];
    advance = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (round !== 4'd0 || valid !== 1'b0 || subkey !== held) begin
        n_fail++;
        $display("FAIL idle_adv c=%0d: round=%0d valid=%b subkey=%h, want 0 0 %h", i, round, valid, subkey, held);
      end
    end
    advance = 1'b0;
    model_keys(KEY_A, 1'b0);
    exp = exp_q.pop_front();
    pulse_load(KEY_A, 1'b0);
    n_tests++;
    if (round !== 4'd0 || valid !== 1'b1 || subkey !== exp) begin
      n_fail++;
      $display("FAIL idle_reload: round=%0d valid=%b subkey=%h, want 0 1 %h", round, valid, subkey, exp);
    end
  endtask

  // Load lands in the first cycle after valid drops.
  task automatic test_back_to_back();
    logic [47:0] exp;
    run_full(KEY_A, 1'b0, 1'b0);
    model_keys(KEY_B, 1'b1);
    exp = exp_q.pop_front();
    pulse_load(KEY_B, 1'b1);
    n_tests++;
    if (round !== 4'd0 || valid !== 1'b1 || subkey !== exp) begin
      n_fail++;
      $display("FAIL b2b: round=%0d valid=%b subkey=%h, want 0 1 %h", round, valid, subkey, exp);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_full({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    do_reset();
    test_encrypt();
    test_decrypt();
    test_parity();
    test_priority();
    test_idle_advance();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES round-key generator sitting directly upstream of the control state machine's round datapath. On a load pulse it applies PC-1 to the 64-bit key, then on each round-advance strobe rotates the C/D halves and presents the next 48-bit round subkey through PC-2. It produces K1..K16 for encryption and K16..K1 for decryption, one subkey per round, with no precomputed key RAM.

## Interface
- Parameters: none. DES geometry (56-bit C/D, 48-bit subkey, 16 rounds) is fixed.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  single-cycle pulse: capture key and decrypt, restart schedule
- key  input  64  DES key, FIPS 46-3 bit 1 = key[63]; parity bits (FIPS 8,16,…,64) ignored
- decrypt  input  1  sampled with load: 0 = K1→K16, 1 = K16→K1
- advance  input  1  step to next round's subkey; driven by the control FSM once per ROUND_PROCESS cycle
- subkey  output  48  current round subkey, FIPS bit 1 = subkey[47]
- round  output  4  index of subkey currently presented, 0..15 in order of use
- valid  output  1  subkey/round meaningful
- last  output  1  valid && round == 15

## Operation
- State: 28-bit C, 28-bit D, 4-bit round counter, 1-bit mode, 1-bit valid. subkey = PC-2(C‖D), combinational from registers (no extra pipeline stage).
- Shift schedule s(n), key number n = 1..16: s = 1 for n ∈ {1,2,9,16}, else 2. Total rotation over 16 rounds = 28.
- load, decrypt=0: {C,D} ← rotl1(PC-1(key)) per half (i.e. C1/D1); round ← 0; valid ← 1; mode ← enc.
- load, decrypt=1: {C,D} ← PC-1(key) (C16 = C0); round ← 0; valid ← 1; mode ← dec.
- advance, valid, round < 15: round ← round+1. Enc: rotate each half left by s(round+2) (target key number). Dec: rotate each half right by s(16 − round) (current key number).
- advance, valid, round == 15: schedule complete; valid ← 0, round ← 0, C/D hold.
- advance while valid == 0: ignored, no state change.
- load and advance in same cycle: load wins; advance discarded.
- load while valid == 1 (mid-schedule): restarts cleanly from new key/mode; previous schedule abandoned.
- key and decrypt only sampled on load; changes at other times have no effect.
- Rotations are within each 28-bit half independently, wrap-around MSB↔LSB.

## Timing
- Reset (async assert, synchronous-safe deassert): C = D = 0, round = 0, valid = 0, mode = enc; therefore subkey = 0, last = 0.
- Latency: load at edge t → subkey = K1 (enc) or K16 (dec), round = 0, valid = 1 visible after edge t, usable in cycle t+1.
- Each advance at edge t → next subkey visible after edge t; one subkey per cycle sustained with advance held high.
- Load followed by 15 consecutive advances: last asserted in the 16th valid cycle; 16th advance drops valid the following cycle.
- Back-to-back: load may be asserted in the same cycle valid falls or any later cycle; no dead cycle required.
- Consumer uses subkey combinationally in the same cycle it is valid; control FSM asserts advance in the cycle it consumes the key.

## Test plan
- Reset: assert rst mid-schedule (round = 7) → immediately valid = 0, round = 0, subkey = 48'h0, last = 0; after release, advance pulses produce no change.
- Encrypt, key 64'h133457799BBCDFF1, load decrypt=0 → cycle after: subkey = 48'h1B02EFFC7072, round = 0; one advance → 48'h79AED9DBC9E5, round = 1; 14 more → 48'hCB3D8B0E17F5, round = 15, last = 1; one more advance → valid = 0.
- Decrypt, same key, load decrypt=1 → subkey = 48'hCB3D8B0E17F5; after 15 advances subkey = 48'h1B02EFFC7072, last = 1; full sequence equals encrypt sequence reversed.
- Parity insensitivity: key 64'h133457799BBCDFF1 vs 64'h123456789ABCDEF0-style parity-flipped variant 64'h123456789BBCDEF0 (bits 8,16,…,64 toggled only) → identical 16 subkeys.
- Priority: assert load (new key 64'h0E329232EA6D0D73) together with advance at round 9 → next cycle round = 0, subkey = K1 of new key, no advance applied.
- Idle advance: after completion (valid = 0), hold advance 5 cycles → round stays 0, subkey unchanged, valid stays 0; subsequent load works normally.
